timer: RTL

TIMER -- requirements
Module: timer

---
 rtl/timer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/timer.sv
// Programmable down-counting timer with a memory-mapped register file.
// Supports one-shot and auto-reload modes and a masked interrupt request.
module timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic        pend_q, pend_d;
  logic [31:0] pre_q, pre_d;
  logic [31:0] cnt_q, cnt_d;

  logic        sel_ctrl;
  logic        sel_pre;
  logic        sel_cnt;
  logic        wr_ctrl;
  logic        wr_pre;
  logic        unused_addr;

  assign unused_addr = ^Addr[31:4];

  assign sel_ctrl = (Addr[3:2] == ADDR_CTRL);
  assign sel_pre  = (Addr[3:2] == ADDR_PRESET);
  assign sel_cnt  = (Addr[3:2] == ADDR_COUNT);

  assign wr_ctrl = WE && sel_ctrl;
  assign wr_pre  = WE && sel_pre;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    mode_d  = mode_q;
    im_d    = im_q;
    pend_d  = pend_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (en_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = pre_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (cnt_q > 32'd1) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          cnt_d   = '0;
          pend_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (mode_q == MODE_RELOAD) begin
          pend_d  = 1'b0;
          state_d = LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus writes land after the FSM so the CPU wins any CTRL conflict.
    if (wr_ctrl) begin
      en_d   = Din[0];
      mode_d = Din[2:1];
      im_d   = Din[3];
      pend_d = 1'b0;
    end
    if (wr_pre) begin
      pre_d = Din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      mode_q  <= 2'b00;
      im_q    <= 1'b0;
      pend_q  <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      im_q    <= im_d;
      pend_q  <= pend_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    Dout = '0;
    unique case (1'b1)
      sel_ctrl: Dout = {28'b0, im_q, mode_q, en_q};
      sel_pre:  Dout = pre_q;
      sel_cnt:  Dout = cnt_q;
      default:  Dout = '0;
    endcase
  end

  assign IRQ = im_q & pend_q;

endmodule
